alu_muldiv: RTL and testbench

- Iterative multiply/divide unit at the consuming end of the ALU operand path.
- Accepts the selected X/Y operands (resultX/resultY of the operand mux) together with a start strobe.
- Computes MIPS mult/multu/div/divu over multiple cycles and holds the results in HI/LO.
- The core decode stalls on busy and, for mfhi/mflo, reads hi/lo after done; mthi/mtlo write HI/LO directly.

---
 rtl/alu_muldiv.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative MIPS mult/multu/div/divu unit with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand conditioning: only the signed ops (op[0]) take magnitudes
  logic               x_neg, y_neg;
  logic [WIDTH-1:0]   x_mag, y_mag;
  assign x_neg = op[0] & x[WIDTH-1];
  assign y_neg = op[0] & y[WIDTH-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  // Multiply: acc = {partial product, remaining multiplier bits}; the carry
  // out of the add is shifted into the top of the accumulator.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, a_q};
  assign div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    x_d       = x_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hiWe) hi_d = wdata;
        if (loWe) lo_d = wdata;
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          x_d       = x;
          dz_d      = op[1] && (y == '0);
          neg_res_d = x_neg ^ y_neg;
          neg_rem_d = x_neg;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? x_mag : y_mag)};
          a_d       = op[1] ? y_mag : x_mag;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          // Divide by zero returns the raw dividend rather than trapping
          hi_d = x_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      x_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      x_q       <= x_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Purpose  : Scoreboard bench for alu_muldiv using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x, y, wdata;
  logic [1:0]  op;
  logic        start, hiWe, loWe;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  string       q_name[$];
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];

  alu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .op    (op),
    .start (start),
    .hiWe  (hiWe),
    .loWe  (loWe),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (q_hi.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        string       nm;
        logic [31:0] eh, el;
        nm = q_name.pop_front();
        eh = q_hi.pop_front();
        el = q_lo.pop_front();
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
      end
    end
  end

  task automatic expect_result(input string name, input logic [31:0] eh, input logic [31:0] el);
    q_name.push_back(name);
    q_hi.push_back(eh);
    q_lo.push_back(el);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    x     = a;
    y     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = $urandom;
    y     = $urandom;
    op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    expect_result(name, eh, el);
    issue(o, a, b);
    wait_done(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    x = '0; y = '0; op = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // multu with busy-length measurement
    expect_result("multu_basic", 32'h0000_0000, 32'h0626_0060);
    issue(2'd0, 32'h1234, 32'h5678);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("multu_busy_cycles", 32'(cnt), 32'd33);
    check("multu_done_pulse", {31'd0, done}, 32'd1);

    // mult then back-to-back divu issued in the done cycle
    run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    expect_result("divu_b2b", 32'h0000_0DA8, 32'h0000_0004);
    issue(2'd2, 32'h5678, 32'h1234);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_busy_high", {31'd0, busy}, 32'd1);
    wait_done("divu_b2b");

    run_op("div_neg7_2",  2'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",     2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_by_zero", 2'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_dz_neg",  2'd3, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("divu_dz",     2'd2, 32'h8000_0005, 32'd0,        32'h8000_0005, 32'hFFFF_FFFF);
    run_op("div_7_neg2",  2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("mult_negneg", 2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
    run_op("multu_max",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // start and mthi during RUN are both ignored
    expect_result("multu_7x9", 32'h0000_0000, 32'h0000_003F);
    issue(2'd0, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    op = 2'd2; x = 32'd100; y = 32'd3; start = 1'b1; hiWe = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; hiWe = 1'b0;
    wait_done("multu_7x9");
    @(negedge clk);
    check("ignored_start_busy", {31'd0, busy}, 32'd0);
    check("ignored_write_hi", hi, 32'd0);

    // mthi/mtlo together in IDLE
    hiWe = 1'b1; loWe = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    hiWe = 1'b0; loWe = 1'b0; wdata = 32'h0;
    check("mthi_hi", hi, 32'h0000_BEEF);
    check("mtlo_lo", lo, 32'h0000_BEEF);

    // reset during RUN discards the operation
    issue(2'd2, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    run_op("multu_after_rst", 2'd0, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006);

    @(negedge clk);
    check("scoreboard_empty", 32'(q_hi.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
